// File: rtl/tt_pin_if.sv
// Pin-side and core-side signal bundle for the pad conditioner.
// slave = conditioner, master = core/pad environment.
interface tt_pin_if #(
  parameter int N_UI  = 8,
  parameter int N_UO  = 8,
  parameter int N_UIO = 8
);
  logic [N_UI-1:0]  pad_ui;
  logic [N_UI-1:0]  core_ui;
  logic [N_UI-1:0]  ui_rise;
  logic [N_UO-1:0]  core_uo;
  logic [N_UO-1:0]  pad_uo;
  logic [N_UIO-1:0] pad_uio_in;
  logic [N_UIO-1:0] core_uio_in;
  logic [N_UIO-1:0] core_uio_out;
  logic [N_UIO-1:0] core_uio_oe;
  logic [N_UIO-1:0] pad_uio_out;
  logic [N_UIO-1:0] pad_uio_oe;
  logic             core_rst_n;

  modport slave (
    input  pad_ui, core_uo, pad_uio_in,
    input  core_uio_out, core_uio_oe,
    output core_ui, ui_rise, pad_uo,
    output core_uio_in, pad_uio_out,
    output pad_uio_oe, core_rst_n
  );

  modport master (
    output pad_ui, core_uo, pad_uio_in,
    output core_uio_out, core_uio_oe,
    input  core_ui, ui_rise, pad_uo,
    input  core_uio_in, pad_uio_out,
    input  pad_uio_oe, core_rst_n
  );
endinterface

// File: rtl/tt_pin_conditioner.sv
// Pad conditioning: input sync/debounce, registered outputs,
// guarded bidir enables and a stretched core reset.
module tt_pin_conditioner #(
  parameter int              N_UI        = 8,
  parameter int              N_UO        = 8,
  parameter int              N_UIO       = 8,
  parameter int              SYNC_STAGES = 2,
  parameter logic [N_UI-1:0] DEB_MASK    = '0,
  parameter int              DEB_CYCLES  = 16,
  parameter int              RST_HOLD    = 16
) (
  input logic     clk,
  input logic     rst,
  tt_pin_if.slave io
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(RST_HOLD + 1);

  logic [SYNC_STAGES-1:0][N_UI-1:0]  ui_sync;
  logic [SYNC_STAGES-1:0][N_UIO-1:0] uio_sync;
  logic [N_UI-1:0]  ui_s;
  logic [N_UI-1:0]  ui_q;
  logic [N_UI-1:0]  ui_d;
  logic [N_UO-1:0]  uo_r;
  logic [N_UIO-1:0] uio_out_r;
  logic [N_UIO-1:0] oe_d1;
  logic [N_UIO-1:0] oe_r;
  logic [RW-1:0]    rst_cnt;
  logic             rstn_r;

  // Metastability chains; stage 0 takes the raw pad.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ui_sync  <= '0;
      uio_sync <= '0;
    end else begin
      ui_sync  <= {ui_sync[SYNC_STAGES-2:0], io.pad_ui};
      uio_sync <= {uio_sync[SYNC_STAGES-2:0], io.pad_uio_in};
    end
  end

  assign ui_s = ui_sync[SYNC_STAGES-1];
  assign io.core_uio_in = uio_sync[SYNC_STAGES-1];

  for (genvar i = 0; i < N_UI; i++) begin : g_ui
    if (DEB_MASK[i]) begin : g_deb
      logic [DW-1:0] cnt;
      logic          q;
      // Flip only after DEB_CYCLES consecutive disagreeing samples.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
          q   <= 1'b0;
        end else if (ui_s[i] == q) begin
          cnt <= '0;
        end else if (cnt == DW'(DEB_CYCLES - 1)) begin
          cnt <= '0;
          q   <= ~q;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
      assign ui_q[i] = q;
    end else begin : g_raw
      assign ui_q[i] = ui_s[i];
    end
  end

  assign io.core_ui = ui_q;
  assign io.ui_rise = ui_q & ~ui_d;

  // Edge history, output retiming and oe guard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ui_d      <= '0;
      uo_r      <= '0;
      uio_out_r <= '0;
      oe_d1     <= '0;
      oe_r      <= '0;
    end else begin
      ui_d      <= ui_q;
      uo_r      <= io.core_uo;
      uio_out_r <= io.core_uio_out;
      oe_d1     <= io.core_uio_oe;
      oe_r      <= io.core_uio_oe & oe_d1;
    end
  end

  assign io.pad_uo      = uo_r;
  assign io.pad_uio_out = uio_out_r;
  assign io.pad_uio_oe  = oe_r;

  // Hold core in reset for RST_HOLD edges after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt <= '0;
      rstn_r  <= 1'b0;
    end else if (!rstn_r) begin
      if (rst_cnt == RW'(RST_HOLD - 1)) begin
        rstn_r <= 1'b1;
      end else begin
        rst_cnt <= rst_cnt + RW'(1);
      end
    end
  end

  assign io.core_rst_n = rstn_r;

endmodule

// File: tb/tb_tt_pin_conditioner.sv
// Directed bench for tt_pin_conditioner: default, debounced
// and odd-width instances on a shared clock and reset.
module tb_tt_pin_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  tt_pin_if #(.N_UI(8), .N_UO(8), .N_UIO(8))  if0 ();
  tt_pin_if #(.N_UI(8), .N_UO(8), .N_UIO(8))  if1 ();
  tt_pin_if #(.N_UI(4), .N_UO(2), .N_UIO(12)) if2 ();

  tt_pin_conditioner dut0 (
    .clk(clk),
    .rst(rst),
    .io (if0)
  );

  tt_pin_conditioner #(
    .DEB_MASK  (8'h01),
    .DEB_CYCLES(4)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .io (if1)
  );

  tt_pin_conditioner #(
    .N_UI       (4),
    .N_UO       (2),
    .N_UIO      (12),
    .SYNC_STAGES(3)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .io (if2)
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if0.pad_ui = '0; if0.core_uo = '0; if0.pad_uio_in = '0;
    if0.core_uio_out = '0; if0.core_uio_oe = '0;
    if1.pad_ui = '0; if1.core_uo = '0; if1.pad_uio_in = '0;
    if1.core_uio_out = '0; if1.core_uio_oe = '0;
    if2.pad_ui = '0; if2.core_uo = '0; if2.pad_uio_in = '0;
    if2.core_uio_out = '0; if2.core_uio_oe = '0;
  endtask

  // Leaves rst released between edges; the next edge is edge 1.
  task automatic reset_seq();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    if0.pad_ui = 8'hFF;
    if0.core_uo = 8'hFF;
    if0.core_uio_oe = 8'hFF;
    if0.core_uio_out = 8'hFF;
    repeat (3) tick();
    check("rst_core_rst_n", 32'(if0.core_rst_n), 0);
    check("rst_pad_uo", 32'(if0.pad_uo), 0);
    check("rst_pad_uio_oe", 32'(if0.pad_uio_oe), 0);
    check("rst_pad_uio_out", 32'(if0.pad_uio_out), 0);
    check("rst_core_ui", 32'(if0.core_ui), 0);
    check("rst_ui_rise", 32'(if0.ui_rise), 0);

    // Sync latency, rise pulse and reset stretch.
    reset_seq();
    if0.pad_ui = 8'h01;
    if0.pad_uio_in = 8'h3C;
    if2.pad_uio_in = 12'hABC;
    for (int e = 1; e <= 17; e++) begin
      tick();
      if (e == 1) check("ui_e1", 32'(if0.core_ui), 0);
      if (e == 2) begin
        check("ui_e2", 32'(if0.core_ui), 8'h01);
        check("rise_e2", 32'(if0.ui_rise), 8'h01);
        check("uio_e2", 32'(if0.core_uio_in), 8'h3C);
        check("uio12_e2", 32'(if2.core_uio_in), 0);
      end
      if (e == 3) begin
        check("rise_e3", 32'(if0.ui_rise), 0);
        check("ui_e3", 32'(if0.core_ui), 8'h01);
        check("uio12_e3", 32'(if2.core_uio_in), 12'hABC);
      end
      if (e == 15) check("rstn_e15", 32'(if0.core_rst_n), 0);
      if (e == 16) check("rstn_e16", 32'(if0.core_rst_n), 1);
    end

    // Debounce: a 3-cycle glitch is rejected.
    reset_seq();
    if1.pad_ui = 8'h01;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) if1.pad_ui = 8'h00;
      if (e == 5) check("glitch_e5", 32'(if1.core_ui), 0);
      if (e == 12) check("glitch_e12", 32'(if1.core_ui), 0);
    end

    // Debounce: held level passes after SYNC+DEB cycles.
    reset_seq();
    if1.pad_ui = 8'h03;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 2) check("deb_raw_e2", 32'(if1.core_ui), 8'h02);
      if (e == 5) check("deb_e5", 32'(if1.core_ui), 8'h02);
      if (e == 6) begin
        check("deb_e6", 32'(if1.core_ui), 8'h03);
        check("deb_rise_e6", 32'(if1.ui_rise), 8'h01);
      end
      if (e == 7) begin
        check("deb_rise_e7", 32'(if1.ui_rise), 0);
        if1.pad_ui = 8'h00;
      end
      if (e == 12) check("deb_fall_e12", 32'(if1.core_ui), 8'h01);
      if (e == 13) check("deb_fall_e13", 32'(if1.core_ui), 0);
    end

    // Output retiming and bidir enable guard.
    reset_seq();
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 5) if0.core_uo = 8'h5A;
      if (e == 5) check("uo_e5", 32'(if0.pad_uo), 0);
      if (e == 6) check("uo_e6", 32'(if0.pad_uo), 8'h5A);
      if (e == 10) begin
        if0.core_uio_oe = 8'h08;
        if0.core_uio_out = 8'h08;
      end
      if (e == 11) begin
        check("uio_out_e11", 32'(if0.pad_uio_out), 8'h08);
        check("oe_e11", 32'(if0.pad_uio_oe), 0);
      end
      if (e == 12) check("oe_e12", 32'(if0.pad_uio_oe), 8'h08);
      if (e == 20) begin
        check("oe_e20", 32'(if0.pad_uio_oe), 8'h08);
        if0.core_uio_oe = 8'h00;
      end
      if (e == 21) begin
        check("oe_e21", 32'(if0.pad_uio_oe), 0);
        check("uio_out_e21", 32'(if0.pad_uio_out), 8'h08);
      end
      if (e == 22) if0.core_uio_oe = 8'h08;
      if (e == 23) if0.core_uio_oe = 8'h00;
      if (e == 24) check("oe_pulse1_e24", 32'(if0.pad_uio_oe), 0);
      if (e == 25) check("oe_pulse1_e25", 32'(if0.pad_uio_oe), 0);
      if (e == 26) if0.core_uio_oe = 8'h08;
      if (e == 27) check("oe_pulse2_e27", 32'(if0.pad_uio_oe), 0);
      if (e == 28) begin
        check("oe_pulse2_e28", 32'(if0.pad_uio_oe), 8'h08);
        if0.core_uio_oe = 8'h00;
      end
      if (e == 29) check("oe_pulse2_e29", 32'(if0.pad_uio_oe), 0);
    end

    // Async reset mid-operation and mid-stretch reload.
    reset_seq();
    if0.core_uo = 8'hA5;
    if0.core_uio_oe = 8'hFF;
    if0.core_uio_out = 8'hFF;
    if0.pad_ui = 8'hFF;
    for (int e = 1; e <= 26; e++) begin
      tick();
      if (e == 8) begin
        check("pre_uo", 32'(if0.pad_uo), 8'hA5);
        check("pre_oe", 32'(if0.pad_uio_oe), 8'hFF);
        check("pre_ui", 32'(if0.core_ui), 8'hFF);
        rst = 1'b1;
        #1;
        check("async_uo", 32'(if0.pad_uo), 0);
        check("async_oe", 32'(if0.pad_uio_oe), 0);
        check("async_out", 32'(if0.pad_uio_out), 0);
        check("async_ui", 32'(if0.core_ui), 0);
        check("async_rstn", 32'(if0.core_rst_n), 0);
      end
      if (e == 9) rst = 1'b0;
      if (e == 24) check("rstn_e24", 32'(if0.core_rst_n), 0);
      if (e == 25) check("rstn_e25", 32'(if0.core_rst_n), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
